// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions: fetch-unit state encoding, reset PC default,
// control-FSM state constants and the PC increment helper.
package instr_fetch_unit_pkg;

  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FS_FETCH   = 2'd0,
    FS_HOLD    = 2'd1,
    FS_DISCARD = 2'd2
  } fetch_state_t;

  typedef enum logic [2:0] {
    CS_RESET     = 3'd0,
    CS_FETCH     = 3'd1,
    CS_DECODE    = 3'd2,
    CS_EXECUTE   = 3'd3,
    CS_MEMORY    = 3'd4,
    CS_WRITEBACK = 3'd5
  } ctrl_state_t;

  function automatic logic [15:0] pc_increment(input logic [15:0] pc);
    return pc + 16'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next.sv
// Next-PC selection: sequential increment (wrapping at 16 bits) or branch target.
module pc_next_logic
  import instr_fetch_unit_pkg::*;
(
  input  logic [15:0] pc,
  input  logic        pc_inc_or_set,
  input  logic [15:0] branch_target,
  output logic [15:0] next_pc
);

  always_comb begin
    next_pc = pc_inc_or_set ? branch_target : pc_increment(pc);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-entry fetch buffer, IR and a
// FETCH/HOLD/DISCARD request FSM that drops responses made stale by a redirect.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_en,
  input  logic        pc_inc_or_set,
  input  logic        ir_en,
  input  logic [15:0] branch_target,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] instruction,
  output logic [15:0] pc,
  output logic        fetch_busy
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  ir_q, ir_d;
  logic [15:0]  fbuf_q, fbuf_d;
  logic [15:0]  addr_q, addr_d;
  logic         pend_q, pend_d;
  logic         req_q, req_d;
  logic [15:0]  pc_next;

  pc_next_logic u_pc_next (
    .pc            (pc_q),
    .pc_inc_or_set (pc_inc_or_set),
    .branch_target (branch_target),
    .next_pc       (pc_next)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    fbuf_d  = fbuf_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    pc_d    = pc_en ? pc_next : pc_q;

    unique case (state_q)
      FS_HOLD: begin
        if (ir_en) ir_d = fbuf_q;
        if (pc_en) begin
          state_d = FS_FETCH;
          addr_d  = pc_next;
        end
      end
      FS_FETCH: begin
        if (mem_ready) begin
          if (pc_en) begin
            // Redirect on the response edge: drop the data, refetch at once.
            addr_d = pc_next;
            pend_d = pend_q | ir_en;
          end else begin
            fbuf_d  = mem_rdata;
            if (pend_q || ir_en) ir_d = mem_rdata;
            pend_d  = 1'b0;
            state_d = FS_HOLD;
          end
        end else begin
          pend_d = pend_q | ir_en;
          if (pc_en) state_d = FS_DISCARD;
        end
      end
      FS_DISCARD: begin
        pend_d = pend_q | ir_en;
        if (mem_ready) begin
          state_d = FS_FETCH;
          addr_d  = pc_d;
        end
      end
      default: state_d = FS_FETCH;
    endcase

    req_d = (state_d != FS_HOLD);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FS_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      fbuf_q  <= '0;
      addr_q  <= RESET_PC;
      pend_q  <= 1'b0;
      req_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fbuf_q  <= fbuf_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
    end
  end

  assign mem_req     = req_q;
  assign mem_addr    = addr_q;
  assign instruction = ir_q;
  assign pc          = pc_q;
  assign fetch_busy  = pend_q;

endmodule
